hbm_stream_write: RTL and testbench

- Parametrised next-generation AXI3 HBM write engine; one instance per pseudo-channel port.
- Issues `write_ops` strided INCR bursts from a latched descriptor.
- Takes payload from an upstream valid/ready stream, with true backpressure instead of free-running data.
- Tracks B responses with a bounded outstanding window; reports completion and a sticky error to the NPU controller.

---
 rtl/hbm_stream_write.sv | 183 ++++++++++++++++++
 tb/tb_hbm_stream_write.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_stream_write.sv
// Strided AXI3 INCR write engine for one HBM pseudo-channel; AW issues one cycle after start, W is a combinational pass-through of the upstream stream.
// Backpressure: WREADY drives up_rdy directly; AW stalls when the outstanding-burst window is full or its address is not yet accepted.
module hbm_stream_write #(
    parameter int ENGINE_ID       = 0,
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 256,
    parameter int ID_WIDTH        = 5,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             write_ops,
    input  logic [31:0]             stride,
    input  logic [ADDR_WIDTH-1:0]   init_addr,
    input  logic [15:0]             mem_burst_size,
    input  logic                    up_vld,
    input  logic [DATA_WIDTH-1:0]   up_dat,
    output logic                    up_rdy,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    m_axi_AWVALID,
    output logic [ADDR_WIDTH-1:0]   m_axi_AWADDR,
    output logic [ID_WIDTH-1:0]     m_axi_AWID,
    output logic [7:0]              m_axi_AWLEN,
    output logic [2:0]              m_axi_AWSIZE,
    output logic [1:0]              m_axi_AWBURST,
    output logic [1:0]              m_axi_AWLOCK,
    output logic [3:0]              m_axi_AWCACHE,
    output logic [2:0]              m_axi_AWPROT,
    output logic [3:0]              m_axi_AWQOS,
    output logic [3:0]              m_axi_AWREGION,
    input  logic                    m_axi_AWREADY,
    output logic                    m_axi_WVALID,
    output logic [DATA_WIDTH-1:0]   m_axi_WDATA,
    output logic [DATA_WIDTH/8-1:0] m_axi_WSTRB,
    output logic                    m_axi_WLAST,
    output logic [ID_WIDTH-1:0]     m_axi_WID,
    input  logic                    m_axi_WREADY,
    input  logic                    m_axi_BVALID,
    input  logic [1:0]              m_axi_BRESP,
    input  logic [ID_WIDTH-1:0]     m_axi_BID,
    output logic                    m_axi_BREADY
);

    localparam int          BEAT_SHIFT = $clog2(DATA_WIDTH/8);
    localparam logic [3:0]  ENGINE_NIB = 4'(ENGINE_ID);
    localparam logic [31:0] MAX_OUT    = 32'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [31:0]           ops_r, stride_r;
    logic [7:0]            len_r, beat_cnt;
    logic [ADDR_WIDTH-1:0] addr_r, base;
    logic [31:0]           aw_cnt, w_burst_cnt, b_cnt;
    logic [31:0]           aw_cnt_nxt, b_cnt_nxt, ops_nxt;
    logic                  awvalid_r, awvalid_nxt, err_r;
    logic [15:0]           burst_beats;
    logic [7:0]            len_new;
    logic                  start_acc, running, permitted;
    logic                  aw_hs, w_hs, b_acc;
    logic                  unused_ok;

    assign burst_beats = mem_burst_size >> BEAT_SHIFT;
    assign len_new     = burst_beats[7:0] - 8'd1;
    assign unused_ok   = ^{m_axi_BID, init_addr[ADDR_WIDTH-1:28], burst_beats[15:8]};

    always_comb begin
        base        = '0;
        base[31:28] = ENGINE_NIB;
        base[27:0]  = init_addr[27:0];
    end

    assign start_acc = start && (state == S_IDLE);
    assign running   = (state == S_RUN);
    // A W beat may only go out for a burst whose address has already been accepted.
    assign permitted = (w_burst_cnt < aw_cnt);
    assign aw_hs     = awvalid_r && m_axi_AWREADY;
    assign w_hs      = m_axi_WVALID && m_axi_WREADY;
    assign b_acc     = m_axi_BVALID && (state != S_IDLE);

    assign m_axi_AWVALID  = awvalid_r;
    assign m_axi_AWADDR   = addr_r;
    assign m_axi_AWID     = '0;
    assign m_axi_AWLEN    = len_r;
    assign m_axi_AWSIZE   = (DATA_WIDTH == 512) ? 3'b110 : 3'b101;
    assign m_axi_AWBURST  = 2'b01;
    assign m_axi_AWLOCK   = 2'b00;
    assign m_axi_AWCACHE  = 4'b0000;
    assign m_axi_AWPROT   = 3'b010;
    assign m_axi_AWQOS    = 4'b0000;
    assign m_axi_AWREGION = 4'b0000;

    assign m_axi_WVALID = up_vld && permitted && running;
    assign m_axi_WDATA  = up_dat;
    assign m_axi_WSTRB  = '1;
    assign m_axi_WLAST  = m_axi_WVALID && (beat_cnt == len_r);
    assign m_axi_WID    = '0;
    assign up_rdy       = m_axi_WREADY && permitted && running;
    assign m_axi_BREADY = 1'b1;
    assign err          = err_r;

    assign aw_cnt_nxt = start_acc ? 32'd0 : aw_cnt + {31'd0, aw_hs};
    assign b_cnt_nxt  = start_acc ? 32'd0 : b_cnt + {31'd0, b_acc};
    assign ops_nxt    = start_acc ? write_ops : ops_r;

    // Look at next-cycle counters so AWVALID rises the cycle after start and reopens as soon as a B frees a slot.
    always_comb begin
        awvalid_nxt = 1'b0;
        if (awvalid_r && !m_axi_AWREADY)
            awvalid_nxt = 1'b1;
        else if (state_nxt == S_RUN)
            awvalid_nxt = (aw_cnt_nxt < ops_nxt) && ((aw_cnt_nxt - b_cnt_nxt) < MAX_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (ops_r == 32'd0)              state_nxt = S_DONE;
                else if (w_burst_cnt == ops_r)   state_nxt = S_DRAIN;
            end
            S_DRAIN: if (b_cnt_nxt == ops_r) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_r       <= '0;
            stride_r    <= '0;
            len_r       <= '0;
            addr_r      <= '0;
            beat_cnt    <= '0;
            aw_cnt      <= '0;
            w_burst_cnt <= '0;
            b_cnt       <= '0;
            awvalid_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            aw_cnt    <= aw_cnt_nxt;
            b_cnt     <= b_cnt_nxt;
            ops_r     <= ops_nxt;
            awvalid_r <= awvalid_nxt;
            if (start_acc) begin
                stride_r    <= stride;
                len_r       <= len_new;
                addr_r      <= base;
                beat_cnt    <= '0;
                w_burst_cnt <= '0;
                err_r       <= 1'b0;
            end else begin
                if (aw_hs)
                    addr_r <= addr_r + ADDR_WIDTH'(stride_r);
                if (w_hs) begin
                    if (beat_cnt == len_r) begin
                        beat_cnt    <= '0;
                        w_burst_cnt <= w_burst_cnt + 32'd1;
                    end else begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                if (b_acc && (m_axi_BRESP != 2'b00))
                    err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hbm_stream_write.sv
// Bench for hbm_stream_write: descriptor table plus random jobs against an arithmetic address/data model, and hand sequences
// for the outstanding window, zero-length jobs, error stickiness and mid-job reset.
module tb_hbm_stream_write;

    localparam int MAXO = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  write_ops = '0, stride = '0;
    logic [32:0]  init_addr = '0;
    logic [15:0]  mem_burst_size = '0;
    logic         up_vld = 1'b0, up_rdy;
    logic [255:0] up_dat = '0;
    logic         busy, done, err;
    logic         awvalid, awready = 1'b0;
    logic [32:0]  awaddr;
    logic [4:0]   awid, wid, bid = '0;
    logic [7:0]   awlen;
    logic [2:0]   awsize, awprot;
    logic [1:0]   awburst, awlock, bresp = '0;
    logic [3:0]   awcache, awqos, awregion;
    logic         wvalid, wready = 1'b0, wlast;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         bvalid = 1'b0, bready;

    hbm_stream_write #(.ENGINE_ID(3), .ADDR_WIDTH(33), .DATA_WIDTH(256), .ID_WIDTH(5), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .start(start), .write_ops(write_ops), .stride(stride), .init_addr(init_addr),
        .mem_burst_size(mem_burst_size), .up_vld(up_vld), .up_dat(up_dat), .up_rdy(up_rdy),
        .busy(busy), .done(done), .err(err),
        .m_axi_AWVALID(awvalid), .m_axi_AWADDR(awaddr), .m_axi_AWID(awid), .m_axi_AWLEN(awlen),
        .m_axi_AWSIZE(awsize), .m_axi_AWBURST(awburst), .m_axi_AWLOCK(awlock), .m_axi_AWCACHE(awcache),
        .m_axi_AWPROT(awprot), .m_axi_AWQOS(awqos), .m_axi_AWREGION(awregion), .m_axi_AWREADY(awready),
        .m_axi_WVALID(wvalid), .m_axi_WDATA(wdata), .m_axi_WSTRB(wstrb), .m_axi_WLAST(wlast),
        .m_axi_WID(wid), .m_axi_WREADY(wready),
        .m_axi_BVALID(bvalid), .m_axi_BRESP(bresp), .m_axi_BID(bid), .m_axi_BREADY(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // knobs owned by the main sequence
    int vld_pct = 100, awr_pct = 100, wr_pct = 100;
    bit b_hold = 1'b0;
    int err_abs = -1, src_lim = 0, stray_req = 0;

    // upstream source and AXI slave, owned by the driver
    int src_cnt = 0, b_sent = 0, stray_done = 0;

    // observations, owned by the monitor
    logic [32:0]  aw_log[$];
    logic [7:0]   awlen_log[$];
    int           aw_cyc_log[$], b_cyc_log[$];
    logic [255:0] w_dat_log[$];
    bit           w_last_log[$];
    int wlast_cnt = 0, done_cnt = 0, done_cyc = 0, last_wl_cyc = 0, last_b_cyc = 0, viol = 0;
    int ep_aw = 0, ep_wl = 0, ep_b = 0;
    bit up_hs_seen = 1'b0, aw_pend = 1'b0, err_at_done = 1'b0;
    logic [32:0] aw_pend_addr = '0;

    int n_chk = 0, n_fail = 0;

    function automatic logic [255:0] beat_data(input int k);
        logic [31:0] x;
        x = 32'(k) * 32'h9E3779B9 + 32'h01234567;
        return {x, ~x, x ^ 32'hA5A5A5A5, x + 32'd1, x, ~x, x ^ 32'h5A5A5A5A, 32'(k)};
    endfunction

    always begin
        bit rst_q, keep;
        @(posedge clk);
        rst_q = rst;
        #1;
        if (up_hs_seen) src_cnt++;
        keep = up_vld && !up_hs_seen;
        if (src_cnt < src_lim) up_vld = keep ? 1'b1 : ($urandom_range(99) < vld_pct);
        else                   up_vld = 1'b0;
        up_dat  = beat_data(src_cnt);
        awready = ($urandom_range(99) < awr_pct);
        wready  = ($urandom_range(99) < wr_pct);
        if (rst_q) b_sent = wlast_cnt;
        bvalid = 1'b0;
        bresp  = 2'b00;
        if (!b_hold && (b_sent < wlast_cnt) && ($urandom_range(1) == 1)) begin
            bvalid = 1'b1;
            bresp  = (b_sent == err_abs) ? 2'b10 : 2'b00;
            b_sent++;
        end else if (stray_done < stray_req) begin
            bvalid = 1'b1;
            bresp  = 2'b10;
            stray_done++;
        end
    end

    always @(negedge clk) begin
        up_hs_seen = up_vld && up_rdy;
        if (rst || (start && !busy)) begin ep_aw = 0; ep_wl = 0; ep_b = 0; end
        if (up_hs_seen != (wvalid && wready)) viol++;
        if (wvalid && (wdata !== up_dat || wstrb !== '1 || wid !== '0)) viol++;
        if (bready !== 1'b1) viol++;
        if (awvalid && (awid !== '0 || awsize !== 3'b101 || awburst !== 2'b01 || awlock !== 2'b00 ||
                        awcache !== 4'd0 || awprot !== 3'b010 || awqos !== 4'd0 || awregion !== 4'd0)) viol++;
        if (aw_pend && (!awvalid || awaddr !== aw_pend_addr)) viol++;
        aw_pend      = awvalid && !awready && !rst;
        aw_pend_addr = awaddr;
        if (awvalid && awready) begin
            aw_log.push_back(awaddr);
            awlen_log.push_back(awlen);
            aw_cyc_log.push_back(cyc);
            ep_aw++;
        end
        if (wvalid && wready) begin
            if (ep_wl >= ep_aw) viol++;
            w_dat_log.push_back(wdata);
            w_last_log.push_back(wlast);
            if (wlast) begin wlast_cnt++; ep_wl++; last_wl_cyc = cyc; end
        end
        if (bvalid) begin
            b_cyc_log.push_back(cyc);
            last_b_cyc = cyc;
            ep_b++;
        end
        if (ep_aw - ep_b > MAXO) viol++;
        if (done) begin done_cnt++; done_cyc = cyc; err_at_done = err; end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int d0, input int budget, input string nm);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin @(negedge clk); k++; end
        chk({nm, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic issue_start(input int ops, input logic [31:0] strd, input logic [32:0] ia,
                               input logic [15:0] bsz, output int t0);
        @(posedge clk); #1;
        write_ops = 32'(ops); stride = strd; init_addr = ia; mem_burst_size = bsz;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    typedef struct {
        int          ops;
        logic [31:0] strd;
        logic [32:0] ia;
        logic [15:0] bsz;
        int          err_rel;
        logic [32:0] exp_first;
        int          exp_len;
        bit          exp_err;
    } vec_t;

    task automatic run_job(input vec_t v, input string nm);
        int beats, total, a0, w0, s0, d0, v0, t0, n, bad, exp_done;
        logic [32:0] base, m;
        beats = v.bsz / 32;
        total = v.ops * beats;
        base  = {1'b0, 4'd3, v.ia[27:0]};
        a0 = aw_log.size(); w0 = w_dat_log.size(); s0 = src_cnt; d0 = done_cnt; v0 = viol;
        err_abs = (v.err_rel < 0) ? -1 : b_sent + v.err_rel;
        src_lim = s0 + total;
        issue_start(v.ops, v.strd, v.ia, v.bsz, t0);
        @(negedge clk);
        chk({nm, "_busy_after_start"}, 64'(busy), 64'd1);
        chk({nm, "_err_cleared"}, 64'(err), 64'd0);
        wait_done(d0, 20000, nm);
        repeat (2) @(negedge clk);
        n = aw_log.size() - a0;
        chk({nm, "_aw_count"}, 64'(n), 64'(v.ops));
        if (v.ops > 0 && n > 0) begin
            chk({nm, "_first_addr"}, 64'(aw_log[a0]), 64'(v.exp_first));
            chk({nm, "_awlen"}, 64'(awlen_log[a0]), 64'(v.exp_len));
        end
        bad = 0;
        for (int i = 0; i < n && i < v.ops; i++) begin
            m = base + 33'(i) * 33'(v.strd);
            if (aw_log[a0+i] !== m || awlen_log[a0+i] !== 8'(beats - 1)) bad++;
        end
        chk({nm, "_addr_seq_bad"}, 64'(bad), 64'd0);
        n = w_dat_log.size() - w0;
        chk({nm, "_w_beats"}, 64'(n), 64'(total));
        bad = 0;
        for (int j = 0; j < n && j < total; j++)
            if (w_dat_log[w0+j] !== beat_data(s0 + j) || w_last_log[w0+j] != ((j % beats) == beats - 1)) bad++;
        chk({nm, "_data_last_bad"}, 64'(bad), 64'd0);
        chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({nm, "_err_at_done"}, 64'(err_at_done), 64'(v.exp_err));
        chk({nm, "_err_sticky"}, 64'(err), 64'(v.exp_err));
        chk({nm, "_busy_end"}, 64'(busy), 64'd0);
        if (v.ops == 0) exp_done = t0 + 2;
        else exp_done = (last_b_cyc + 1 > last_wl_cyc + 3) ? last_b_cyc + 1 : last_wl_cyc + 3;
        chk({nm, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({nm, "_protocol_viol"}, 64'(viol - v0), 64'd0);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        int a0, w0, d0, nb, t0, beats;

        tbl[0] = '{1, 32'h0,         33'h0_0000_0100, 16'd1024, -1, 33'h0_3000_0100, 31,  1'b0};
        tbl[1] = '{4, 32'h1000,      33'h0_0000_0000, 16'd64,   -1, 33'h0_3000_0000, 1,   1'b0};
        tbl[2] = '{3, 32'h20,        33'h1_FFFF_FFE0, 16'd32,    1, 33'h0_3FFF_FFE0, 0,   1'b1};
        tbl[3] = '{0, 32'h40,        33'h0_0000_0200, 16'd64,   -1, 33'h0_3000_0200, 1,   1'b0};
        tbl[4] = '{4, 32'hFFFF_FFFF, 33'h0_0FFF_FFFF, 16'd32,   -1, 33'h0_3FFF_FFFF, 0,   1'b0};
        tbl[5] = '{2, 32'h100,       33'h0_0000_0040, 16'd8192, -1, 33'h0_3000_0040, 255, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 64'({awvalid, wvalid, up_rdy, busy, done, err}), 64'd0);
        chk("reset_bready", 64'(bready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            vld_pct = (i < 2) ? 100 : 50;
            wr_pct  = (i < 2) ? 100 : 50;
            awr_pct = (i < 2) ? 100 : 50;
            run_job(tbl[i], $sformatf("tbl%0d", i));
        end

        // outstanding window: two AWs, then stall until a B frees a slot
        vld_pct = 100; wr_pct = 100; awr_pct = 100; err_abs = -1;
        a0 = aw_log.size(); w0 = w_dat_log.size(); d0 = done_cnt;
        src_lim = src_cnt + 4;
        b_hold = 1'b1;
        issue_start(4, 32'h80, 33'h0, 16'd32, t0);
        repeat (30) @(negedge clk);
        chk("ostd_aw_stalled", 64'(aw_log.size() - a0), 64'd2);
        chk("ostd_awvalid_low", 64'(awvalid), 64'd0);
        chk("ostd_w_continues", 64'(w_dat_log.size() - w0), 64'd2);
        nb = b_cyc_log.size();
        b_hold = 1'b0;
        wait_done(d0, 2000, "ostd");
        chk("ostd_aw_total", 64'(aw_log.size() - a0), 64'd4);
        if (aw_log.size() - a0 > 2 && b_cyc_log.size() > nb)
            chk("ostd_third_after_b", 64'(aw_cyc_log[a0+2] > b_cyc_log[nb]), 64'd1);

        // reset in the middle of a job
        repeat (3) @(negedge clk);
        w0 = w_dat_log.size(); d0 = done_cnt;
        src_lim = src_cnt + 16;
        issue_start(2, 32'h400, 33'h0, 16'd256, t0);
        for (int k = 0; k < 200 && (w_dat_log.size() - w0) < 5; k++) @(negedge clk);
        chk("rst_five_beats", 64'(w_dat_log.size() - w0 >= 5), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs", 64'({awvalid, wvalid, up_rdy, busy, done}), 64'd0);
        repeat (4) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        src_lim = src_cnt;
        stray_req++;
        repeat (4) @(negedge clk);
        chk("idle_b_ignored", 64'({err, busy}), 64'd0);
        vld_pct = 50; wr_pct = 50; awr_pct = 50;
        run_job(tbl[1], "post_rst");

        for (int r = 0; r < 8; r++) begin
            beats     = $urandom_range(1, 8);
            v.ops     = $urandom_range(0, 5);
            v.strd    = $urandom;
            v.ia      = {1'($urandom_range(1)), 32'($urandom)};
            v.bsz     = 16'(beats * 32);
            v.err_rel = (v.ops > 0 && $urandom_range(2) == 0) ? $urandom_range(0, v.ops - 1) : -1;
            v.exp_first = {1'b0, 4'd3, v.ia[27:0]};
            v.exp_len = beats - 1;
            v.exp_err = (v.err_rel >= 0);
            vld_pct = $urandom_range(30, 100);
            wr_pct  = $urandom_range(30, 100);
            awr_pct = $urandom_range(30, 100);
            run_job(v, $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
